vga_pixel_prefetch: RTL and testbench

Upstream pixel source for the VGA timing generator. Reads a 640x480 RGB565 frame from external memory over an Avalon-MM-style pipelined read port and buffers it in a small FIFO. On each `i_request` from the timing generator it presents one expanded 8-8-8 pixel on the next cycle. Between frames it flushes and re-primes the FIFO during vertical blanking, so the first pixel of every frame is ready when `i_frame_start` arrives.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/vga_pixel_prefetch.sv | 180 ++++++++++++++++++
 tb/tb_vga_pixel_prefetch.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel path: prefetcher state encoding,
// 640x480@60 timing constants, and the RGB565 -> RGB888 colour expansion.
// ----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } pf_state_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicating the top bits into the new LSBs maps full-scale 565 values
    // to full-scale 888 values (0x1F -> 0xFF) and zero to zero.
    function automatic rgb888_t rgb565_to_888(input logic [15:0] w);
        rgb888_t p;
        p.r = {w[15:11], w[15:13]};
        p.g = {w[10:5],  w[10:9]};
        p.b = {w[4:0],   w[4:2]};
        return p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock fall-through FIFO: o_rdata always shows the head word, so a
// pop and the consumer's output register land in the same cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push/i_wdata write one word (ignored when full unless also popping)
//   i_pop         drop the head word (ignored when empty)
//   i_clear       empty the FIFO; wins over push and pop
//   o_rdata       head word
//   o_count       words held, 0..DEPTH
//   o_empty/o_full status
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_pixel_prefetch.sv
// ----------------------------------------------------------------------------
// vga_pixel_prefetch
// Streams a frame of RGB565 words from memory into a small FIFO and hands
// one expanded 8-8-8 pixel per request to the VGA timing generator, one
// cycle after the request. i_frame_end flushes and re-primes the FIFO from
// a freshly sampled base address so each frame starts aligned.
// Ports:
//   clk, rst                   pixel clock, synchronous active-high reset
//   i_base_addr                frame buffer base (sampled at frame bounds)
//   i_request                  pixel wanted on the next cycle
//   i_frame_start              frame start marker (alignment uses frame end)
//   i_frame_end                last active pixel of the frame
//   o_R, o_G, o_B              registered pixel
//   mem_addr, mem_read         pipelined read request
//   mem_waitrequest            request not accepted this cycle
//   mem_readdata/valid         in-order read returns
//   o_underflow                sticky: a request found the FIFO empty
// ----------------------------------------------------------------------------
module vga_pixel_prefetch #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 20,
    parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_request,
    input  logic              i_frame_start,
    input  logic              i_frame_end,
    output logic [7:0]        o_R,
    output logic [7:0]        o_G,
    output logic [7:0]        o_B,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [15:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic              o_underflow
);

    import vga_pkg::*;

    localparam int CW   = $clog2(DEPTH+1);
    localparam int AC_W = $clog2(FRAME_PIXELS+1);

    pf_state_t         r_state;
    pf_state_t         w_state_next;
    logic              r_first;
    logic [ADDR_W-1:0] r_base;
    logic [AC_W-1:0]   r_addr_cnt;
    logic [CW-1:0]     r_outst;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [7:0]        r_R;
    logic [7:0]        r_G;
    logic [7:0]        r_B;
    logic              r_underflow;

    logic [15:0]       w_fifo_rdata;
    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_room;
    logic              w_more;
    logic              w_issue;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;

    // Frame start carries no information the frame-end flush does not.
    assign w_unused = &{i_frame_start, w_fifo_full};

    assign w_fetch_addr = r_base + ADDR_W'(r_addr_cnt);
    // Counting in-flight reads against FIFO space guarantees every return
    // has a slot, so the FIFO can never overflow.
    assign w_room   = (32'(w_fifo_count) + 32'(r_outst)) < 32'(DEPTH);
    assign w_more   = 32'(r_addr_cnt) < 32'(FRAME_PIXELS);
    // r_first blocks the cycle where the base register is still loading.
    assign w_issue  = (r_state == S_FETCH) && !r_first && w_more && w_room;
    assign w_accept = mem_read && !mem_waitrequest;
    assign w_push   = mem_readdatavalid && (r_state != S_FLUSH) && !i_frame_end;
    assign w_pop    = i_request && !w_fifo_empty && !i_frame_end;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (i_frame_end),
        .i_wdata (mem_readdata),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (i_frame_end) begin
            w_state_next = S_FLUSH;
        end else begin
            case (r_state)
                S_FETCH: if (!w_more) w_state_next = S_HOLD;
                S_FLUSH: if (!r_pend && r_outst == '0) w_state_next = S_FETCH;
                default: w_state_next = r_state;
            endcase
        end
    end

    // In S_FLUSH only a read caught stalled at frame end is presented, with
    // its captured address, since base and addr_cnt have already moved on.
    always_comb begin
        mem_read = w_issue;
        mem_addr = w_fetch_addr;
        if (r_state == S_FLUSH) begin
            mem_read = r_pend;
            mem_addr = r_pend_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first     <= 1'b1;
            r_base      <= '0;
            r_addr_cnt  <= '0;
            r_outst     <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_R         <= '0;
            r_G         <= '0;
            r_B         <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (r_first) begin
                r_first <= 1'b0;
                r_base  <= i_base_addr;
            end
            // Accept and return in one cycle cancel out.
            r_outst <= r_outst + CW'(w_accept) - CW'(mem_readdatavalid);
            if (i_frame_end) begin
                r_base      <= i_base_addr;
                r_addr_cnt  <= '0;
                r_pend      <= mem_read && mem_waitrequest;
                r_pend_addr <= mem_addr;
                r_R         <= '0;
                r_G         <= '0;
                r_B         <= '0;
            end else begin
                if (r_state == S_FETCH && w_accept) r_addr_cnt <= r_addr_cnt + AC_W'(1);
                if (r_state == S_FLUSH && w_accept) r_pend <= 1'b0;
                if (i_request) begin
                    if (!w_fifo_empty) begin
                        {r_R, r_G, r_B} <= rgb565_to_888(w_fifo_rdata);
                    end else begin
                        r_R         <= '0;
                        r_G         <= '0;
                        r_B         <= '0;
                        r_underflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_R         = r_R;
    assign o_G         = r_G;
    assign o_B         = r_B;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
module tb_vga_pixel_prefetch;
    import vga_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 20;
    localparam int FP     = 48;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic              i_request = 1'b0;
    logic              i_frame_start = 1'b0;
    logic              i_frame_end = 1'b0;
    logic [7:0]        o_R, o_G, o_B;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_waitrequest = 1'b0;
    logic [15:0]       mem_readdata = '0;
    logic              mem_readdatavalid = 1'b0;
    logic              o_underflow;

    always #5 clk = ~clk;

    vga_pixel_prefetch #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_base_addr       (i_base_addr),
        .i_request         (i_request),
        .i_frame_start     (i_frame_start),
        .i_frame_end       (i_frame_end),
        .o_R               (o_R),
        .o_G               (o_G),
        .o_B               (o_B),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .o_underflow       (o_underflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory contents: a few hand-picked colours, incrementing words elsewhere.
    function automatic logic [15:0] word(input logic [ADDR_W-1:0] a);
        case (a)
            20'h100: return 16'hF800;
            20'h101: return 16'h07E0;
            20'h102: return 16'h001F;
            20'h103: return 16'hFFFF;
            20'h104: return 16'h0000;
            20'h105: return 16'h8410;
            default: return a[15:0];
        endcase
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] w);
        int r, g, b;
        r = int'(w[15:11]);
        g = int'(w[10:5]);
        b = int'(w[4:0]);
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    // ---------------- memory model (acts on the falling edge) ----------------
    typedef struct {
        int          due;
        logic [15:0] d;
    } rsp_t;

    rsp_t              pq[$];
    logic [ADDR_W-1:0] rlog[$];
    int                ncyc = 0;
    int                lat = 3;
    int                stall_at = -1;
    int                stall_rem = 0;
    int                stable_bad = 0;
    logic              prev_wait = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge clk) begin
        ncyc++;
        if (prev_wait && !(mem_read === 1'b1 && mem_addr === prev_addr)) stable_bad++;
        if (rst) begin
            mem_waitrequest   = 1'b0;
            mem_readdatavalid = 1'b0;
            pq.delete();
            prev_wait = 1'b0;
        end else begin
            mem_waitrequest = 1'b0;
            if (mem_read && rlog.size() == stall_at && stall_rem > 0) begin
                mem_waitrequest = 1'b1;
                stall_rem--;
            end
            prev_wait = mem_read && mem_waitrequest;
            prev_addr = mem_addr;
            if (mem_read && !mem_waitrequest) begin
                rlog.push_back(mem_addr);
                pq.push_back('{ncyc + lat, word(mem_addr)});
            end
            mem_readdatavalid = 1'b0;
            if (pq.size() > 0 && pq[0].due <= ncyc) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = pq[0].d;
                void'(pq.pop_front());
            end
        end
    end

    task automatic wait_full(input string name);
        int n = 0;
        while (32'(dut.w_fifo_count) != DEPTH && n < 300) begin
            tick;
            n++;
        end
        chk(name, 32'(n < 300), 32'd1);
    endtask

    task automatic frame_end_pulse;
        i_frame_end = 1'b1;
        tick;
        i_frame_end = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [ADDR_W-1:0] a);
        i_request = 1'b1;
        tick;
        i_request = 1'b0;
        chk(name, {8'h0, o_R, o_G, o_B}, {8'h0, expand(word(a))});
    endtask

    typedef struct {
        logic       req;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    vec_t vt[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int errs;
        int n;

        vt[0] = '{1'b1, 8'hFF, 8'h00, 8'h00};
        vt[1] = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vt[2] = '{1'b0, 8'h00, 8'hFF, 8'h00};
        vt[3] = '{1'b1, 8'h00, 8'h00, 8'hFF};
        vt[4] = '{1'b1, 8'hFF, 8'hFF, 8'hFF};
        vt[5] = '{1'b1, 8'h00, 8'h00, 8'h00};
        vt[6] = '{1'b1, 8'h84, 8'h82, 8'h84};
        vt[7] = '{1'b0, 8'h84, 8'h82, 8'h84};

        // ---------------- reset and prefill ----------------
        i_base_addr = 20'h100;
        lat = 3;
        rst = 1'b1;
        tick;
        tick;
        chk("reset_R", 32'(o_R), 32'h0);
        chk("reset_G", 32'(o_G), 32'h0);
        chk("reset_B", 32'(o_B), 32'h0);
        chk("reset_mem_read", 32'(mem_read), 32'h0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk("reset_underflow", 32'(o_underflow), 32'h0);
        rlog.delete();
        rst = 1'b0;
        wait_full("prefill_timeout");
        repeat (4) tick;
        chk("prefill_reads", 32'(rlog.size()), 32'(DEPTH));
        errs = 0;
        foreach (rlog[i]) if (rlog[i] !== 20'h100 + ADDR_W'(i)) errs++;
        chk("prefill_addr_order", 32'(errs), 32'h0);
        chk("prefill_mem_read_low", 32'(mem_read), 32'h0);
        chk("prefill_fifo_count", 32'(dut.w_fifo_count), 32'(DEPTH));

        // ---------------- colour expansion and latency ----------------
        for (int i = 0; i < 8; i++) begin
            i_request = vt[i].req;
            tick;
            chk($sformatf("vec%0d_R", i), 32'(o_R), 32'(vt[i].r));
            chk($sformatf("vec%0d_G", i), 32'(o_G), 32'(vt[i].g));
            chk($sformatf("vec%0d_B", i), 32'(o_B), 32'(vt[i].b));
        end
        i_request = 1'b0;

        // ---------------- mid-flight frame end ----------------
        lat = 6;
        i_base_addr = 20'h300;
        frame_end_pulse;
        rlog.delete();
        stable_bad = 0;
        stall_at = 4;
        stall_rem = 20;
        n = 0;
        while (mem_waitrequest !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        chk("midflight_stall_seen", 32'(n < 100), 32'd1);
        chk("midflight_outstanding", 32'(dut.r_outst), 32'd4);
        chk("midflight_reads", 32'(rlog.size()), 32'd4);
        i_base_addr = 20'h400;
        frame_end_pulse;
        chk("midflight_flush_state", 32'(dut.r_state), 32'(S_FLUSH));
        chk("midflight_black", {8'h0, o_R, o_G, o_B}, 32'h0);
        wait_full("midflight_refill_timeout");
        repeat (3) tick;
        chk("midflight_total_reads", 32'(rlog.size()), 32'd21);
        chk("midflight_stalled_addr", 32'((rlog.size() > 5) ? rlog[4] : '1), 32'h304);
        chk("midflight_new_base", 32'((rlog.size() > 5) ? rlog[5] : '1), 32'h400);
        chk("midflight_stall_stable", 32'(stable_bad), 32'h0);
        pop_check("midflight_first_pixel", 20'h400);
        pop_check("midflight_second_pixel", 20'h401);

        // ---------------- stall on the third read ----------------
        lat = 2;
        i_base_addr = 20'h500;
        frame_end_pulse;
        rlog.delete();
        stable_bad = 0;
        stall_at = 2;
        stall_rem = 5;
        wait_full("stall_refill_timeout");
        repeat (3) tick;
        chk("stall_used", 32'(stall_rem), 32'h0);
        chk("stall_reads", 32'(rlog.size()), 32'(DEPTH));
        errs = 0;
        foreach (rlog[i]) if (rlog[i] !== 20'h500 + ADDR_W'(i)) errs++;
        chk("stall_addr_order", 32'(errs), 32'h0);
        chk("stall_stable", 32'(stable_bad), 32'h0);
        stall_at = -1;
        pop_check("stall_first_pixel", 20'h500);

        // ---------------- underflow ----------------
        rst = 1'b1;
        lat = 40;
        i_base_addr = 20'h600;
        tick;
        tick;
        rlog.delete();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_request = 1'b1;
            tick;
            chk($sformatf("underflow_black%0d", i), {8'h0, o_R, o_G, o_B}, 32'h0);
        end
        i_request = 1'b0;
        chk("underflow_set", 32'(o_underflow), 32'h1);
        wait_full("underflow_refill_timeout");
        pop_check("underflow_recovered_pixel", 20'h600);
        chk("underflow_sticky", 32'(o_underflow), 32'h1);

        // ---------------- full frame ----------------
        rst = 1'b1;
        lat = 3;
        i_base_addr = 20'h2000;
        tick;
        tick;
        rst = 1'b0;
        wait_full("frame1_fill_timeout");
        frame_end_pulse;
        rlog.delete();
        wait_full("frame2_fill_timeout");
        errs = 0;
        for (int i = 0; i < FP; i++) begin
            i_request = 1'b1;
            i_frame_start = (i == 0);
            tick;
            if ({o_R, o_G, o_B} !== expand(word(20'h2000 + ADDR_W'(i)))) errs++;
        end
        i_request = 1'b0;
        i_frame_start = 1'b0;
        chk("frame_pixel_order", 32'(errs), 32'h0);
        repeat (8) tick;
        chk("frame_no_underflow", 32'(o_underflow), 32'h0);
        chk("frame_read_count", 32'(rlog.size()), 32'(FP));
        chk("frame_hold_state", 32'(dut.r_state), 32'(S_HOLD));
        chk("frame_hold_no_read", 32'(mem_read), 32'h0);
        chk("frame_fifo_drained", 32'(dut.w_fifo_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
